energy_noise_estimator: RTL and testbench

- Front-end producer for the detection comparator.
- Consumes a stream of signed samples and computes sum-of-squares energy over fixed windows.
- Maintains a running noise-floor estimate as an IIR average of past window energies.
- Presents signal_out, noise_out and a one-cycle ready pulse to the comparator's signal_in, noise_in and ready inputs.

---
 rtl/energy_noise_estimator.sv | 117 +++++++++++
 tb/tb_energy_noise_estimator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/energy_noise_estimator.sv
// Windowed sum-of-squares energy plus IIR noise-floor estimate for the detection comparator.
// Optional build macro NOISE_FREEZE_EN adds det_in, which freezes the noise floor on detections.
module energy_noise_estimator #(
  parameter int WIN_LOG2    = 4,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
`ifdef NOISE_FREEZE_EN
  input  logic        det_in,
`endif
  output logic [31:0] signal_out,
  output logic [31:0] noise_out,
  output logic        ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [WIN_LOG2-1:0]   count;
  logic [30:0]           sq;
  logic                  sq_valid;
  logic                  sq_last;
  logic [31:0]           acc;
  logic [31:0]           energy;
  logic                  e_valid;
  logic [31:0]           noise;

  logic [30:0]           square;
  logic [32:0]           acc_sum;
  logic [31:0]           acc_next;
  logic signed [33:0]    noise_diff;
  logic signed [33:0]    noise_step;
  logic [31:0]           noise_next;
  logic                  freeze;

  // A 16x16 signed square never exceeds 2^30, so 31 bits hold it exactly.
  assign square = 31'($signed(sample_in) * $signed(sample_in));

  // The carry out of the 33-bit sum doubles as the saturation flag; once the
  // accumulator reads all-ones any further add carries out and it stays pinned.
  assign acc_sum  = {1'b0, acc} + {2'b00, sq};
  assign acc_next = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];

  // Signed shift of the difference gives floor division; the result stays
  // between the old noise value and the new energy, so it always fits 32 bits.
  assign noise_diff = $signed({2'b00, energy}) - $signed({2'b00, noise});
  assign noise_step = noise_diff >>> ALPHA_SHIFT;
  assign noise_next = 32'($signed({2'b00, noise}) + noise_step);

`ifdef NOISE_FREEZE_EN
  assign freeze = det_in;
`else
  assign freeze = 1'b0;
`endif

  // NOTE: every register below uses non-blocking assignment so the three
  // pipeline stages all read the values from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state      <= INIT;
      count      <= '0;
      sq         <= '0;
      sq_valid   <= 1'b0;
      sq_last    <= 1'b0;
      acc        <= '0;
      energy     <= '0;
      e_valid    <= 1'b0;
      noise      <= '0;
      signal_out <= '0;
      noise_out  <= '0;
      ready      <= 1'b0;
    end else begin
      // Stage 1: square the accepted sample and tag the last one of the window.
      sq_valid <= sample_valid;
      if (sample_valid) begin
        sq      <= square;
        sq_last <= &count;
        count   <= count + 1'b1;
      end

      // Stage 2: accumulate; the window's final add hands off E and restarts at 0.
      e_valid <= 1'b0;
      if (sq_valid) begin
        if (sq_last) begin
          energy  <= acc_next;
          e_valid <= 1'b1;
          acc     <= '0;
        end else begin
          acc <= acc_next;
        end
      end

      // Stage 3: seed the noise floor on the first window, then report and track.
      ready <= 1'b0;
      if (e_valid) begin
        case (state)
          INIT: begin
            noise <= energy;
            state <= RUN;
          end
          RUN: begin
            signal_out <= energy;
            noise_out  <= noise;
            ready      <= 1'b1;
            if (!freeze) noise <= noise_next;
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_energy_noise_estimator.sv
// Randomized and directed bench for energy_noise_estimator against a window-level reference model.
// Build with NOISE_FREEZE_EN defined to exercise the det_in noise freeze as well.
module tb_energy_noise_estimator;

  localparam int WIN_LOG2    = 2;
  localparam int ALPHA_SHIFT = 3;
  localparam int WIN         = 1 << WIN_LOG2;
  localparam longint MAX32   = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        det = 1'b0;
  logic [31:0] signal_out;
  logic [31:0] noise_out;
  logic        ready;

  energy_noise_estimator #(.WIN_LOG2(WIN_LOG2), .ALPHA_SHIFT(ALPHA_SHIFT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (restart),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
`ifdef NOISE_FREEZE_EN
    .det_in       (det),
`endif
    .signal_out   (signal_out),
    .noise_out    (noise_out),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d (0x%h), expected %0d (0x%h)", tag, cyc, got, got, exp, exp);
    end
  endtask

  // Expected output events, each tagged with the edge at which it must appear.
  typedef struct {
    int          due;
    bit          clr;
    logic [31:0] sig;
    logic [31:0] noi;
  } ev_t;
  ev_t evq[$];

  // Reference model state: whole-window arithmetic in wide integers.
  bit     m_init = 1'b1;
  int     m_cnt  = 0;
  longint m_sum  = 0;
  longint m_noise = 0;

  function automatic longint floor_div(longint num, longint den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  // One clock of stimulus; the model sees the same inputs the next edge will sample.
  task automatic step(bit v, logic [15:0] s, bit rs, bit rn);
    int     edge_n;
    int     sv;
    longint e;
    @(posedge clk);
    #1;
    sample_valid = v;
    sample_in    = s;
    restart      = rs;
    rst_n        = rn;
    edge_n       = cyc + 1;
    if (rs || !rn) begin
      while (evq.size() > 0 && evq[$].due >= edge_n) void'(evq.pop_back());
      evq.push_back('{due: edge_n, clr: 1'b1, sig: '0, noi: '0});
      m_init = 1'b1; m_cnt = 0; m_sum = 0; m_noise = 0;
    end else if (v) begin
      sv = $signed(s);
      m_sum += longint'(sv) * sv;
      m_cnt++;
      if (m_cnt == WIN) begin
        e = (m_sum > MAX32) ? MAX32 : m_sum;
        if (m_init) begin
          m_noise = e;
          m_init  = 1'b0;
        end else begin
          evq.push_back('{due: edge_n + 2, clr: 1'b0, sig: e[31:0], noi: m_noise[31:0]});
          if (!det) m_noise = m_noise + floor_div(e - m_noise, longint'(1) << ALPHA_SHIFT);
          check("noise_range", (m_noise >= 0 && m_noise <= MAX32), 1'b1);
        end
        m_cnt = 0; m_sum = 0;
      end
    end
  endtask

  task automatic window(logic [15:0] s);
    for (int i = 0; i < WIN; i++) step(1'b1, s, 1'b0, 1'b1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic expect_out(string tag, logic [31:0] sig, logic [31:0] noi);
    check({tag, "_signal"}, signal_out, sig);
    check({tag, "_noise"}, noise_out, noi);
  endtask

  // Every cycle: ready must match the expected pulse and outputs must hold their model values.
  logic [31:0] held_sig = '0;
  logic [31:0] held_noi = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      automatic bit  exp_rdy = 1'b0;
      automatic ev_t ev;
      if (evq.size() > 0 && evq[0].due < cyc) begin
        ev = evq.pop_front();
        check("missed_event", 32'(cyc), 32'(ev.due));
      end
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        if (ev.clr) begin
          held_sig = '0;
          held_noi = '0;
        end else begin
          held_sig = ev.sig;
          held_noi = ev.noi;
          exp_rdy  = 1'b1;
        end
      end
      check("ready", ready, exp_rdy);
      check("signal_out", signal_out, held_sig);
      check("noise_out", noise_out, held_noi);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst_n  = 1'b1;
    check("reset_signal", signal_out, 32'd0);
    check("reset_noise", noise_out, 32'd0);
    check("reset_ready", ready, 1'b0);

    // Seed window, then the documented noise trajectory 400 -> 550 -> 481.
    window(16'd10);
    idle(3);
    expect_out("init_window", 32'd0, 32'd0);
    window(16'd20);
    idle(3);
    expect_out("win2", 32'd1600, 32'd400);
    window(16'd0);
    idle(3);
    expect_out("win3", 32'd0, 32'd550);
    window(16'd5);
    idle(3);
    expect_out("win4", 32'd100, 32'd481);

    // Saturation at the negative extreme, exact result at the positive one.
    window(16'h8000);
    idle(3);
    check("sat_neg", signal_out, 32'hFFFF_FFFF);
    window(16'h7FFF);
    idle(3);
    check("unsat_pos", signal_out, 32'd4294705156);

    // Gapped samples, then back-to-back windows.
    for (int i = 0; i < WIN; i++) begin
      step(1'b1, 16'(i * 7 + 3), 1'b0, 1'b1);
      step(1'b0, 16'hDEAD, 1'b0, 1'b1);
    end
    idle(3);
    for (int w = 0; w < 4; w++) window(16'(w * 100 - 150));
    idle(3);

    // Restart mid-window: outputs clear, next full window is a silent seed.
    step(1'b1, 16'd20, 1'b0, 1'b1);
    step(1'b1, 16'd20, 1'b0, 1'b1);
    step(1'b1, 16'd20, 1'b1, 1'b1);
    idle(3);
    expect_out("after_restart", 32'd0, 32'd0);
    window(16'd10);
    idle(3);
    expect_out("restart_seed", 32'd0, 32'd0);
    window(16'd20);
    idle(3);
    expect_out("restart_run", 32'd1600, 32'd400);

    // Same sequence through rst_n.
    step(1'b1, 16'd20, 1'b0, 1'b1);
    step(1'b1, 16'd20, 1'b0, 1'b1);
    step(1'b1, 16'd20, 1'b0, 1'b0);
    idle(3);
    expect_out("after_rst_n", 32'd0, 32'd0);
    window(16'd10);
    idle(3);
    expect_out("rst_n_seed", 32'd0, 32'd0);
    window(16'd20);
    idle(3);
    expect_out("rst_n_run", 32'd1600, 32'd400);

`ifdef NOISE_FREEZE_EN
    step(1'b0, '0, 1'b1, 1'b1);
    window(16'd10);
    idle(3);
    det = 1'b1;
    window(16'd20);
    idle(3);
    det = 1'b0;
    window(16'd0);
    idle(3);
    expect_out("freeze_on", 32'd0, 32'd400);
    step(1'b0, '0, 1'b1, 1'b1);
    window(16'd10);
    window(16'd20);
    window(16'd0);
    idle(3);
    expect_out("freeze_off", 32'd0, 32'd550);
`endif

    // Random traffic with occasional restarts and extreme samples.
    for (int i = 0; i < 600; i++) begin
      automatic bit          v  = ($urandom_range(0, 3) != 0);
      automatic bit          rs = ($urandom_range(0, 149) == 0);
      automatic logic [15:0] s;
      case ($urandom_range(0, 7))
        0:       s = 16'h8000;
        1:       s = 16'h7FFF;
        2:       s = 16'(int'($urandom_range(0, 40)) - 20);
        default: s = 16'($urandom);
      endcase
      step(v, s, rs, 1'b1);
    end
    idle(4);
    check("events_drained", 32'(evq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
